uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide: pclk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: preset  input  1  reset, synchronous and active-high.
REQ-003 SHALL provide: ctrl_en  input  1  UART enable; 0 forces transmitter idle.
REQ-004 SHALL provide: ctrl_tx_en  input  1  one-cycle write strobe pushing ctrl_data into TX FIFO.
REQ-005 SHALL provide: ctrl_data  input  8  byte to transmit.
REQ-006 SHALL provide: ctrl_shift_tx  input  1  one-pclk pulse marking each bit-period boundary.
REQ-007 SHALL provide: ctrl_d9  input  1  1 = append parity bit after data.
REQ-008 SHALL provide: ctrl_ep  input  1  parity select: 1 = even, 0 = odd.
REQ-009 SHALL provide: ctrl_txt  input  2  TX empty-threshold select.
REQ-010 SHALL provide: uart_txd  output  1  serial line, registered, idle high.
REQ-011 SHALL provide: tx_nf  output  1  FIFO not full.
REQ-012 SHALL provide: tx_busy  output  1  serializer not in IDLE.
REQ-013 SHALL provide: tx_txe  output  1  FIFO level at/below threshold.

Function
REQ-014 SHALL implement a 16-entry x 8-bit FIFO with 5-bit count (0..16), 4-bit wrapping read/write pointers.
REQ-015 SHALL push on ctrl_tx_en only if count < 16 at that cycle; write while full SHALL be dropped with no state change, even if a pop occurs the same cycle.
REQ-016 SHALL handle push and pop in the same cycle with count unchanged and both pointers advanced.
REQ-017 SHALL drive tx_nf = (count != 16), combinational from registered count.
REQ-018 SHALL drive tx_txe from count: txt=00 -> count==0; 01 -> count<=4; 10 -> count<=8; 11 -> count<=12.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; tx_busy = (state != IDLE).
REQ-020 IDLE: on ctrl_shift_tx with count>0 and ctrl_en=1, SHALL pop head into 8-bit shift register, load bit index 0, go START; otherwise stay IDLE.
REQ-021 START SHALL drive txd=0; next ctrl_shift_tx -> DATA.
REQ-022 DATA SHALL drive shift-register LSB; each ctrl_shift_tx shifts right and increments bit index; after bit 7 -> PARITY if ctrl_d9=1, else STOP.
REQ-023 PARITY SHALL drive XOR of the 8 data bits when ctrl_ep=1, its inverse when ctrl_ep=0; next ctrl_shift_tx -> STOP.
REQ-024 STOP SHALL drive txd=1; next ctrl_shift_tx -> START with a new pop if count>0, else IDLE.
REQ-025 Each bit SHALL hold on uart_txd exactly from one ctrl_shift_tx pulse to the next; uart_txd changes one pclk after the pulse (registered).
REQ-026 ctrl_d9/ctrl_ep SHALL be sampled when DATA exits; parity SHALL be computed from the popped byte, not the live FIFO.
REQ-027 ctrl_en=0 SHALL force state IDLE and uart_txd=1 on the next edge, aborting any frame in progress; the aborted byte is lost; FIFO contents and writes unaffected.
REQ-028 ctrl_shift_tx pulses in IDLE with count==0 SHALL have no effect.

Reset
REQ-029 On preset=1 at a rising edge: state IDLE, count 0, pointers 0, shift register 0, uart_txd=1, tx_nf=1, tx_busy=0, tx_txe=1.
REQ-030 Reset SHALL override all other inputs, including mid-frame, and SHALL discard FIFO contents.

Verification
REQ-031 Reset, ctrl_en=1, d9=0, write 0xA5, pulse shift every 16 clk -> txd: 0,1,0,1,0,0,1,0,1,1 then idle 1; tx_busy high throughout frame.
REQ-032 d9=1, ep=1, write 0x07 -> parity bit 1; ep=0 -> parity bit 0; frame 11 bits.
REQ-033 Write 17 bytes with no shift pulses -> tx_nf=0 after 16th, 17th dropped; then 16 frames transmit in order 0x00..0x0F with no idle bit between frames.
REQ-034 txt=01: load 6 bytes -> tx_txe=0; tx_txe rises when count drops to 4.
REQ-035 Drop ctrl_en in DATA bit 3 -> next cycle txd=1, tx_busy=0; re-enable -> next byte sent whole; assert preset mid-frame -> all outputs at reset values next cycle.
REQ-036 FIFO full, ctrl_tx_en coincident with pop -> count 15 after edge, written byte absent from output stream.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a 16-deep byte FIFO.
// Bit timing comes from an external ctrl_shift_tx pulse; the line is registered.
module uart_tx_fifo (
    input  logic       pclk,
    input  logic       preset,
    input  logic       ctrl_en,
    input  logic       ctrl_tx_en,
    input  logic [7:0] ctrl_data,
    input  logic       ctrl_shift_tx,
    input  logic       ctrl_d9,
    input  logic       ctrl_ep,
    input  logic [1:0] ctrl_txt,
    output logic       uart_txd,
    output logic       tx_nf,
    output logic       tx_busy,
    output logic       tx_txe
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem_q [16];
    logic [4:0]  count_q, count_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        push;
    logic        pop;
    logic [7:0]  head;

    assign head     = mem_q[rd_ptr_q];
    assign push     = ctrl_tx_en && (count_q != 5'd16);
    assign tx_nf    = (count_q != 5'd16);
    assign tx_busy  = (state_q != IDLE);
    assign uart_txd = txd_q;

    always_comb begin
        tx_txe = 1'b0;
        unique case (ctrl_txt)
            2'b00: tx_txe = (count_q == 5'd0);
            2'b01: tx_txe = (count_q <= 5'd4);
            2'b10: tx_txe = (count_q <= 5'd8);
            2'b11: tx_txe = (count_q <= 5'd12);
            default: tx_txe = 1'b0;
        endcase
    end

    // txd_d is the level for the bit period that begins at this edge.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (!ctrl_en) begin
            state_d = IDLE;
            txd_d   = 1'b1;
        end else if (ctrl_shift_tx) begin
            unique case (state_q)
                IDLE, STOP: begin
                    if (count_q != 5'd0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        idx_d   = 3'd0;
                        par_d   = ^head;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
                START: begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
                DATA: begin
                    if (idx_q == 3'd7) begin
                        if (ctrl_d9) begin
                            state_d = PARITY;
                            txd_d   = ctrl_ep ? par_q : ~par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + {3'b000, pop};
        wr_ptr_d = wr_ptr_q + {3'b000, push};
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            rd_ptr_q <= 4'd0;
            wr_ptr_q <= 4'd0;
            shift_q  <= 8'd0;
            idx_q    <= 3'd0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset && push) begin
            mem_q[wr_ptr_q] <= ctrl_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo.
// Expected line levels are written out by hand per frame.
module tb_uart_tx_fifo;

    logic       pclk = 1'b0;
    logic       preset;
    logic       ctrl_en;
    logic       ctrl_tx_en;
    logic [7:0] ctrl_data;
    logic       ctrl_shift_tx;
    logic       ctrl_d9;
    logic       ctrl_ep;
    logic [1:0] ctrl_txt;
    logic       uart_txd;
    logic       tx_nf;
    logic       tx_busy;
    logic       tx_txe;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo dut (
        .pclk          (pclk),
        .preset        (preset),
        .ctrl_en       (ctrl_en),
        .ctrl_tx_en    (ctrl_tx_en),
        .ctrl_data     (ctrl_data),
        .ctrl_shift_tx (ctrl_shift_tx),
        .ctrl_d9       (ctrl_d9),
        .ctrl_ep       (ctrl_ep),
        .ctrl_txt      (ctrl_txt),
        .uart_txd      (uart_txd),
        .tx_nf         (tx_nf),
        .tx_busy       (tx_busy),
        .tx_txe        (tx_txe)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset;
        preset = 1'b1;
        tick;
        preset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        ctrl_tx_en = 1'b1;
        ctrl_data  = b;
        tick;
        ctrl_tx_en = 1'b0;
    endtask

    task automatic bit_pulse(input string tag, input logic exp,
                             input int gap);
        ctrl_shift_tx = 1'b1;
        tick;
        ctrl_shift_tx = 1'b0;
        check(tag, uart_txd, exp);
        check({tag, "_busy"}, tx_busy, 1);
        repeat (gap - 1) tick;
        check({tag, "_hold"}, uart_txd, exp);
    endtask

    task automatic idle_pulse(input string tag);
        ctrl_shift_tx = 1'b1;
        tick;
        ctrl_shift_tx = 1'b0;
        check({tag, "_txd"}, uart_txd, 1);
        check({tag, "_busy"}, tx_busy, 0);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b,
                              input logic has_par, input logic par,
                              input int gap);
        bit_pulse({tag, "_start"}, 1'b0, gap);
        for (int i = 0; i < 8; i++) begin
            bit_pulse($sformatf("%s_d%0d", tag, i), b[i], gap);
        end
        if (has_par) bit_pulse({tag, "_par"}, par, gap);
        bit_pulse({tag, "_stop"}, 1'b1, gap);
    endtask

    initial begin
        logic [9:0] a5_exp;
        logic [7:0] b36;
        a5_exp        = 10'b1101001010;
        preset        = 1'b1;
        ctrl_en       = 1'b1;
        ctrl_tx_en    = 1'b0;
        ctrl_data     = 8'h00;
        ctrl_shift_tx = 1'b0;
        ctrl_d9       = 1'b0;
        ctrl_ep       = 1'b0;
        ctrl_txt      = 2'b00;
        repeat (3) tick;
        preset = 1'b0;
        check("rst_txd", uart_txd, 1);
        check("rst_nf", tx_nf, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_txe", tx_txe, 1);
        idle_pulse("empty_pulse");

        // 0xA5, no parity, 16-clock bit period
        wr(8'hA5);
        check("a5_txe", tx_txe, 0);
        repeat (5) tick;
        for (int i = 0; i < 10; i++) begin
            bit_pulse($sformatf("a5_b%0d", i), a5_exp[i], 16);
        end
        idle_pulse("a5_end");

        // 0x07 has three ones: even -> 1, odd -> 0
        ctrl_d9 = 1'b1;
        ctrl_ep = 1'b1;
        wr(8'h07);
        send_frame("p07e", 8'h07, 1'b1, 1'b1, 3);
        idle_pulse("p07e_end");
        ctrl_ep = 1'b0;
        wr(8'h07);
        send_frame("p07o", 8'h07, 1'b1, 1'b0, 3);
        idle_pulse("p07o_end");
        ctrl_d9 = 1'b0;

        // 17 writes, last dropped; 16 back-to-back frames
        for (int i = 0; i < 17; i++) begin
            wr(8'(i));
            if (i == 14) check("fill15_nf", tx_nf, 1);
            if (i == 15) check("fill16_nf", tx_nf, 0);
        end
        check("fill17_nf", tx_nf, 0);
        for (int i = 0; i < 16; i++) begin
            send_frame($sformatf("s%0d", i), 8'(i), 1'b0, 1'b0, 2);
        end
        idle_pulse("stream_end");

        // empty threshold
        do_reset;
        ctrl_txt = 2'b01;
        for (int i = 0; i < 6; i++) wr(8'h11 + 8'(i));
        check("txe01_6", tx_txe, 0);
        ctrl_txt = 2'b10;
        #1 check("txe10_6", tx_txe, 1);
        ctrl_txt = 2'b11;
        #1 check("txe11_6", tx_txe, 1);
        ctrl_txt = 2'b00;
        #1 check("txe00_6", tx_txe, 0);
        ctrl_txt = 2'b01;
        send_frame("t34a", 8'h11, 1'b0, 1'b0, 1);
        check("txe01_5", tx_txe, 0);
        bit_pulse("t34b_start", 1'b0, 1);
        check("txe01_4", tx_txe, 1);
        ctrl_txt = 2'b00;

        // disable mid-frame during DATA bit 3
        do_reset;
        wr(8'h3C);
        wr(8'h81);
        bit_pulse("ab_start", 1'b0, 1);
        bit_pulse("ab_d0", 1'b0, 1);
        bit_pulse("ab_d1", 1'b0, 1);
        bit_pulse("ab_d2", 1'b1, 1);
        bit_pulse("ab_d3", 1'b1, 1);
        ctrl_en = 1'b0;
        tick;
        check("ab_txd", uart_txd, 1);
        check("ab_busy", tx_busy, 0);
        ctrl_en = 1'b1;
        tick;
        send_frame("x81", 8'h81, 1'b0, 1'b0, 2);
        idle_pulse("x81_end");

        // reset mid-frame discards FIFO
        wr(8'h55);
        wr(8'h66);
        bit_pulse("pr_start", 1'b0, 1);
        bit_pulse("pr_d0", 1'b1, 1);
        preset = 1'b1;
        tick;
        preset = 1'b0;
        check("pr_txd", uart_txd, 1);
        check("pr_busy", tx_busy, 0);
        check("pr_nf", tx_nf, 1);
        check("pr_txe", tx_txe, 1);
        idle_pulse("pr_after");

        // full FIFO, write coincident with pop is dropped
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
        check("f36_nf", tx_nf, 0);
        ctrl_shift_tx = 1'b1;
        ctrl_tx_en    = 1'b1;
        ctrl_data     = 8'hEE;
        tick;
        ctrl_shift_tx = 1'b0;
        ctrl_tx_en    = 1'b0;
        check("f36_nf15", tx_nf, 1);
        check("f36_start", uart_txd, 0);
        ctrl_txt = 2'b11;
        #1 check("f36_txe15", tx_txe, 0);
        ctrl_txt = 2'b00;
        b36 = 8'h20;
        for (int i = 0; i < 8; i++) begin
            bit_pulse($sformatf("f36_d%0d", i), b36[i], 1);
        end
        bit_pulse("f36_stop", 1'b1, 1);
        for (int i = 1; i < 16; i++) begin
            send_frame($sformatf("f36_s%0d", i), 8'h20 + 8'(i),
                       1'b0, 1'b0, 1);
        end
        idle_pulse("f36_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
